mul_seg_pipe: RTL and testbench
===============================

// Module: mul_seg_pipe
// PURPOSE
//  Parametrised, fully pipelined signed multiplier A x B built from a chain of dsp_25x18 slices.
//  B is split into 17-bit unsigned low segments plus one signed top segment; partial products
//  are summed through the PCI cascade with 17-bit arithmetic shifts.
//  Adds a valid pipeline, output scaling (arithmetic right shift), saturation and an overflow flag.
//  Used in codec_fir for coefficient x sample products wider than 24x35.
// PARAMETERS
//  A_W    24  width of signed a; range 2..25 (sign-extended to 25 at DSP A input)
//  B_W    35  width of signed b; range 18..69; N_SEG = ceil((B_W-1)/17) slices (1..4)
//  SHIFT  0   arithmetic right shift applied to full product before output; 0..A_W+B_W-1
//  OUT_W  59  width of output m; 2..A_W+B_W
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         a/b valid this cycle
//  a          in   A_W       signed multiplicand
//  b          in   B_W       signed multiplier
//  out_valid  out  1         m/out_sat valid
//  m          out  OUT_W     signed scaled product
//  out_sat    out  1         1 = m clipped to +max/-min this sample
// BEHAVIOUR
//  - Segment k (0..N_SEG-1): b bits [17k+16:17k], zero-extended to 18b for k<N_SEG-1;
//    top segment = b[B_W-1:17(N_SEG-1)] sign-extended to 18b. Every slice gets {sign-ext a}.
//  - Slice k input regs depth k+1 (skew); pci_k = p_{k-1} >>> 17 (sign-ext), pci_0 = 0.
//  - Low 17 bits of p_k (k<N_SEG-1) delayed by N_SEG-1-k cycles to align; full product
//    P (A_W+B_W bits) = {p_top, aligned low chunks}. Exact, no truncation inside.
//  - Output stage (1 register): S = P >>> SHIFT (floor); if S > 2^(OUT_W-1)-1 -> m = +max,
//    out_sat = 1; if S < -2^(OUT_W-1) -> m = -min, out_sat = 1; else m = S[OUT_W-1:0], out_sat = 0.
//  - Latency LAT = N_SEG + 2 cycles, in_valid -> out_valid; (a,b) sampled with in_valid.
//  - Throughput 1 per cycle; no backpressure; in_valid gaps propagate as out_valid gaps
//    with identical spacing. Data regs free-run; only valid path gates meaning.
//  - out_valid = 0 => m and out_sat hold their previous values (output reg enabled by valid).
//  - Reset: valid shift register cleared, out_valid = 0, m = 0, out_sat = 0 on the cycle after
//    rst is sampled high; in-flight samples discarded, never emerge after rst deasserts.
//    in_valid while rst = 1 ignored. First valid after release appears LAT cycles later.
//  - Elaboration: $error if A_W>25, B_W<18, B_W>69, SHIFT or OUT_W out of range.
// CONFIGURATION
//  MUL_ROUND_EN defined: S = (P + 2^(SHIFT-1)) >>> SHIFT (round half up) when SHIFT>0, with the
//    rounding add done at width A_W+B_W+1 so it cannot wrap; saturation applied after rounding;
//    latency unchanged.
//  MUL_ROUND_EN undefined: floor (pure arithmetic shift), no adder in output stage.
// TESTING
//  1 defaults (A_W=24,B_W=35,SHIFT=0,OUT_W=59): a=-1,b=1 -> m=-1, out_valid exactly 4 cycles later.
//  2 defaults: a=-2^23,b=-2^34 -> m=2^57, out_sat=0; a=2^23-1,b=-2^34 -> m=-(2^57-2^34).
//  3 OUT_W=24,SHIFT=30: a=2^23-1,b=2^34-1 -> m=24'h7FFFFF, out_sat=1; negate b -> m=24'h800000, out_sat=1.
//  4 SHIFT=4,OUT_W=16: a=3,b=3 -> m=0 (no macro) / 1 (MUL_ROUND_EN); a=-3,b=3 -> m=-1 both.
//  5 B_W=52 (N_SEG=3), 1000 random back-to-back + random in_valid gaps vs. behavioural
//    model -> bit-exact, LAT=5, gap pattern preserved.
//  6 rst pulsed 1 cycle with 3 samples in flight -> out_valid=0,m=0 next cycle; no stale
//    outputs; next sample after release correct at LAT.

Source files
------------

// File: rtl/mul_seg_pipe.sv
// Fully pipelined signed A x B multiplier built from a cascade of 25x18 DSP-style slices,
// with valid pipeline, arithmetic-shift scaling, saturation and an overflow flag.
// Optional build macro MUL_ROUND_EN selects round-half-up scaling instead of floor.
module mul_seg_pipe #(
  parameter int A_W   = 24,
  parameter int B_W   = 35,
  parameter int SHIFT = 0,
  parameter int OUT_W = 59
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] m,
  output logic                    out_sat
);

  localparam int N_SEG = (B_W + 15) / 17;
  localparam int LAT   = N_SEG + 2;
  localparam int P_W   = A_W + B_W;
  localparam int LOW_W = 17 * (N_SEG - 1);
  localparam int PT_W  = P_W - LOW_W;

  localparam logic signed [P_W:0] MAXV = {{(P_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [P_W:0] MINV = ~MAXV;
`ifdef MUL_ROUND_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [P_W:0] RND = (SHIFT > 0) ? ((P_W + 1)'(1) << RSH) : '0;
`endif

  if (A_W < 2 || A_W > 25) begin : g_chk_a
    $error("mul_seg_pipe: A_W=%0d outside 2..25", A_W);
  end
  if (B_W < 18 || B_W > 69) begin : g_chk_b
    $error("mul_seg_pipe: B_W=%0d outside 18..69", B_W);
  end
  if (SHIFT < 0 || SHIFT > P_W - 1) begin : g_chk_shift
    $error("mul_seg_pipe: SHIFT=%0d outside 0..%0d", SHIFT, P_W - 1);
  end
  if (OUT_W < 2 || OUT_W > P_W) begin : g_chk_out
    $error("mul_seg_pipe: OUT_W=%0d outside 2..%0d", OUT_W, P_W);
  end

  logic signed [24:0]      a_ext;
  logic [N_SEG-1:0][17:0]  seg;
  logic [N_SEG-1:0][47:0]  pci;
  logic [P_W-1:0]          p_full;
  logic signed [P_W:0]     ext_d;
  logic signed [P_W:0]     s_d;
  logic [LAT-1:0]          vld_q;
  logic signed [OUT_W-1:0] m_q, m_d;
  logic                    sat_q, sat_d;

  assign a_ext  = 25'(a);
  assign pci[0] = '0;

  // Slice k sees its operands k+1 cycles late so it lines up with the cascade from slice k-1.
  for (genvar k = 0; k < N_SEG; k++) begin : g_slice
    logic signed [24:0] a_q [k+1];
    logic signed [17:0] s_q [k+1];

    if (k < N_SEG - 1) begin : g_seg_lo
      assign seg[k] = {1'b0, b[17*k +: 17]};
    end else begin : g_seg_top
      assign seg[k] = 18'($signed(b[B_W-1:LOW_W]));
    end

    always_ff @(posedge clk) begin
      a_q[0] <= a_ext;
      s_q[0] <= seg[k];
      for (int j = 1; j <= k; j++) begin
        a_q[j] <= a_q[j-1];
        s_q[j] <= s_q[j-1];
      end
    end

    if (k < N_SEG - 1) begin : g_lo
      localparam int D = N_SEG - 1 - k;
      logic signed [47:0] p_q;
      logic [16:0]        lo_q [D];

      always_ff @(posedge clk) begin
        p_q     <= 48'(a_q[k]) * 48'(s_q[k]) + $signed(pci[k]);
        lo_q[0] <= p_q[16:0];
        for (int j = 1; j < D; j++) begin
          lo_q[j] <= lo_q[j-1];
        end
      end

      assign pci[k+1]            = p_q >>> 17;
      assign p_full[17*k +: 17]  = lo_q[D-1];
    end else begin : g_top
      logic signed [PT_W-1:0] p_q;

      always_ff @(posedge clk) begin
        p_q <= PT_W'(48'(a_q[k]) * 48'(s_q[k]) + $signed(pci[k]));
      end

      assign p_full[P_W-1:LOW_W] = p_q;
    end
  end

  // Scaling runs one bit wider than the product so the rounding add can never wrap.
  always_comb begin
    ext_d = (P_W + 1)'($signed(p_full));
`ifdef MUL_ROUND_EN
    s_d   = (ext_d + RND) >>> SHIFT;
`else
    s_d   = ext_d >>> SHIFT;
`endif
    m_d   = s_d[OUT_W-1:0];
    sat_d = 1'b0;
    if (s_d > MAXV) begin
      m_d   = MAXV[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (s_d < MINV) begin
      m_d   = MINV[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      m_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
      if (vld_q[LAT-2]) begin
        m_q   <= m_d;
        sat_q <= sat_d;
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign m         = m_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_mul_seg_pipe.sv
// Self-checking bench for mul_seg_pipe: four instances cover the default, saturating,
// small-shift and three-slice configurations; expected results flow through a scoreboard queue.
module tb_mul_seg_pipe;

  localparam int LAT2 = 4;
  localparam int LAT3 = 5;
  localparam int SH3  = 9;
  localparam int OW3  = 60;
  localparam int NRND = 1000;

  typedef struct {
    logic signed [127:0] m;
    logic                sat;
    int                  stamp;
  } exp_t;

  exp_t sbq [$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               inValid0 = 1'b0;
  logic signed [23:0] a0 = '0;
  logic signed [34:0] b0 = '0;
  logic               outValid0;
  logic signed [58:0] m0;
  logic               outSat0;

  logic               inValid1 = 1'b0;
  logic signed [23:0] a1 = '0;
  logic signed [34:0] b1 = '0;
  logic               outValid1;
  logic signed [23:0] m1;
  logic               outSat1;

  logic               inValid2 = 1'b0;
  logic signed [23:0] a2 = '0;
  logic signed [34:0] b2 = '0;
  logic               outValid2;
  logic signed [15:0] m2;
  logic               outSat2;

  logic               inValid3 = 1'b0;
  logic signed [23:0] a3 = '0;
  logic signed [51:0] b3 = '0;
  logic               outValid3;
  logic signed [59:0] m3;
  logic               outSat3;

  mul_seg_pipe #(.A_W(24), .B_W(35), .SHIFT(0), .OUT_W(59)) u0 (
    .clk(clk), .rst(rst), .in_valid(inValid0), .a(a0), .b(b0),
    .out_valid(outValid0), .m(m0), .out_sat(outSat0));

  mul_seg_pipe #(.A_W(24), .B_W(35), .SHIFT(30), .OUT_W(24)) u1 (
    .clk(clk), .rst(rst), .in_valid(inValid1), .a(a1), .b(b1),
    .out_valid(outValid1), .m(m1), .out_sat(outSat1));

  mul_seg_pipe #(.A_W(24), .B_W(35), .SHIFT(4), .OUT_W(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(inValid2), .a(a2), .b(b2),
    .out_valid(outValid2), .m(m2), .out_sat(outSat2));

  mul_seg_pipe #(.A_W(24), .B_W(52), .SHIFT(SH3), .OUT_W(OW3)) u3 (
    .clk(clk), .rst(rst), .in_valid(inValid3), .a(a3), .b(b3),
    .out_valid(outValid3), .m(m3), .out_sat(outSat3));

  // Free-running clock and a cycle stamp used to measure latency per sample.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference for the three-slice instance: exact wide multiply, then scale and clip.
  function automatic logic [128:0] model3(input logic signed [23:0] av, input logic signed [51:0] bv);
    logic signed [127:0] p, s, mx, mn;
    p = 128'(av) * 128'(bv);
`ifdef MUL_ROUND_EN
    p = p + (128'sd1 <<< (SH3 - 1));
`endif
    s  = p >>> SH3;
    mx = (128'sd1 <<< (OW3 - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (OW3 - 1));
    if (s > mx) return {1'b1, mx};
    if (s < mn) return {1'b1, mn};
    return {1'b0, s};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({outValid0, outSat0, m0} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_u0 got v=%b s=%b m=%0h want all zero", outValid0, outSat0, m0);
    end
    compared++;
    if ({outValid1, outSat1, m1} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_u1 got v=%b s=%b m=%0h want all zero", outValid1, outSat1, m1);
    end
    compared++;
    if ({outValid2, outSat2, m2} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_u2 got v=%b s=%b m=%0h want all zero", outValid2, outSat2, m2);
    end
    compared++;
    if ({outValid3, outSat3, m3} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_u3 got v=%b s=%b m=%0h want all zero", outValid3, outSat3, m3);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_latency;
    int lat;
    @(posedge clk);
    #1 inValid0 = 1'b1; a0 = -24'sd1; b0 = 35'sd1;
    @(posedge clk);
    #1 inValid0 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (outValid0) lat = i;
    end
    compared++;
    if (lat !== LAT2) begin
      mismatched++;
      $display("[TB] FAIL latency got %0d want %0d (0 = never)", lat, LAT2);
    end
    compared++;
    if (m0 !== -59'sd1) begin
      mismatched++;
      $display("[TB] FAIL neg_one got %0h want %0h", m0, -59'sd1);
    end
    compared++;
    if (outSat0 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL neg_one_sat got %b want 0", outSat0);
    end
    @(negedge clk);
    compared++;
    if (outValid0 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL valid_pulse got %b want 0", outValid0);
    end
    compared++;
    if (m0 !== -59'sd1) begin
      mismatched++;
      $display("[TB] FAIL hold got %0h want %0h", m0, -59'sd1);
    end
  endtask

  task automatic test_back_to_back;
    logic signed [23:0] ta [4];
    logic signed [34:0] tbv [4];
    logic signed [58:0] tm [4];
    int got;
    exp_t e;
    ta  = '{-24'sd8388608, 24'sd8388607, -24'sd1, 24'sd12345};
    tbv = '{35'sh4_0000_0000, 35'sh4_0000_0000, 35'sd1, -35'sd678};
    tm  = '{59'sh200_0000_0000_0000, -59'sh1FF_FFFC_0000_0000, -59'sd1, -59'sd8369910};
    sbq.delete();
    got = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          #1 inValid0 = 1'b1; a0 = ta[i]; b0 = tbv[i];
          sbq.push_back('{m: 128'(tm[i]), sat: 1'b0, stamp: cyc});
        end
        @(posedge clk);
        #1 inValid0 = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge clk);
          if (outValid0) begin
            compared++;
            if (sbq.size() == 0) begin
              mismatched++;
              $display("[TB] FAIL b2b_spurious got out_valid with empty scoreboard");
            end else begin
              e = sbq.pop_front();
              if (m0 !== e.m[58:0]) begin
                mismatched++;
                $display("[TB] FAIL b2b_m[%0d] got %0h want %0h", got, m0, e.m[58:0]);
              end
              compared++;
              if (outSat0 !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL b2b_sat[%0d] got %b want %b", got, outSat0, e.sat);
              end
              compared++;
              if (cyc - e.stamp !== LAT2) begin
                mismatched++;
                $display("[TB] FAIL b2b_lat[%0d] got %0d want %0d", got, cyc - e.stamp, LAT2);
              end
            end
            got++;
          end
        end
      end
    join
    compared++;
    if (got !== 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_count got %0d want 4", got);
    end
  endtask

  task automatic test_saturation;
    logic signed [23:0] ta [3];
    logic signed [34:0] tbv [3];
    logic signed [23:0] tm [3];
    logic               ts [3];
    int got;
    exp_t e;
    ta  = '{24'sd8388607, 24'sd8388607, 24'sd1};
    tbv = '{35'sd17179869183, -35'sd17179869183, 35'sd1073741824};
    tm  = '{24'sh7FFFFF, 24'sh800000, 24'sd1};
    ts  = '{1'b1, 1'b1, 1'b0};
    sbq.delete();
    got = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1 inValid1 = 1'b1; a1 = ta[i]; b1 = tbv[i];
          sbq.push_back('{m: 128'(tm[i]), sat: ts[i], stamp: cyc});
        end
        @(posedge clk);
        #1 inValid1 = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 3; c++) begin
          @(negedge clk);
          if (outValid1) begin
            compared++;
            if (sbq.size() == 0) begin
              mismatched++;
              $display("[TB] FAIL sat_spurious got out_valid with empty scoreboard");
            end else begin
              e = sbq.pop_front();
              if (m1 !== e.m[23:0]) begin
                mismatched++;
                $display("[TB] FAIL sat_m[%0d] got %0h want %0h", got, m1, e.m[23:0]);
              end
              compared++;
              if (outSat1 !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL sat_flag[%0d] got %b want %b", got, outSat1, e.sat);
              end
              compared++;
              if (cyc - e.stamp !== LAT2) begin
                mismatched++;
                $display("[TB] FAIL sat_lat[%0d] got %0d want %0d", got, cyc - e.stamp, LAT2);
              end
            end
            got++;
          end
        end
      end
    join
    compared++;
    if (got !== 3) begin
      mismatched++;
      $display("[TB] FAIL sat_count got %0d want 3", got);
    end
  endtask

  task automatic test_rounding;
    logic signed [23:0] ta [4];
    logic signed [34:0] tbv [4];
    logic signed [15:0] tm [4];
    logic               ts [4];
    int got;
    exp_t e;
    ta  = '{24'sd3, -24'sd3, 24'sd5, 24'sd8388607};
    tbv = '{35'sd3, 35'sd3, -35'sd5, 35'sd1048576};
`ifdef MUL_ROUND_EN
    tm  = '{16'sd1, -16'sd1, -16'sd2, 16'sh7FFF};
`else
    tm  = '{16'sd0, -16'sd1, -16'sd2, 16'sh7FFF};
`endif
    ts  = '{1'b0, 1'b0, 1'b0, 1'b1};
    sbq.delete();
    got = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          #1 inValid2 = 1'b1; a2 = ta[i]; b2 = tbv[i];
          sbq.push_back('{m: 128'(tm[i]), sat: ts[i], stamp: cyc});
        end
        @(posedge clk);
        #1 inValid2 = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge clk);
          if (outValid2) begin
            compared++;
            if (sbq.size() == 0) begin
              mismatched++;
              $display("[TB] FAIL rnd_spurious got out_valid with empty scoreboard");
            end else begin
              e = sbq.pop_front();
              if (m2 !== e.m[15:0]) begin
                mismatched++;
                $display("[TB] FAIL rnd_m[%0d] got %0h want %0h", got, m2, e.m[15:0]);
              end
              compared++;
              if (outSat2 !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL rnd_sat[%0d] got %b want %b", got, outSat2, e.sat);
              end
              compared++;
              if (cyc - e.stamp !== LAT2) begin
                mismatched++;
                $display("[TB] FAIL rnd_lat[%0d] got %0d want %0d", got, cyc - e.stamp, LAT2);
              end
            end
            got++;
          end
        end
      end
    join
    compared++;
    if (got !== 4) begin
      mismatched++;
      $display("[TB] FAIL rnd_count got %0d want 4", got);
    end
  endtask

  task automatic test_random;
    int got, idle;
    logic signed [51:0] bt;
    logic [128:0] r;
    exp_t e;
    sbq.delete();
    got  = 0;
    idle = 0;
    fork
      begin
        for (int i = 0; i < NRND; i++) begin
          @(posedge clk);
          #1;
          if ($urandom_range(0, 3) == 0) begin
            inValid3 = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk);
              #1;
            end
          end
          bt = 52'({$urandom(), $urandom()});
          a3 = 24'($urandom());
          b3 = bt >>> $urandom_range(0, 40);
          if (i % 97 == 0) a3 = 24'sh800000;
          if (i % 89 == 0) b3 = 52'sh8_0000_0000_0000;
          inValid3 = 1'b1;
          r = model3(a3, b3);
          sbq.push_back('{m: $signed(r[127:0]), sat: r[128], stamp: cyc});
        end
        @(posedge clk);
        #1 inValid3 = 1'b0;
      end
      begin
        while (got < NRND && idle < 50) begin
          @(negedge clk);
          if (outValid3) begin
            idle = 0;
            compared++;
            if (sbq.size() == 0) begin
              mismatched++;
              $display("[TB] FAIL rand_spurious got out_valid with empty scoreboard");
            end else begin
              e = sbq.pop_front();
              if (m3 !== e.m[59:0]) begin
                mismatched++;
                $display("[TB] FAIL rand_m[%0d] got %0h want %0h", got, m3, e.m[59:0]);
              end
              compared++;
              if (outSat3 !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL rand_sat[%0d] got %b want %b", got, outSat3, e.sat);
              end
              compared++;
              if (cyc - e.stamp !== LAT3) begin
                mismatched++;
                $display("[TB] FAIL rand_lat[%0d] got %0d want %0d", got, cyc - e.stamp, LAT3);
              end
            end
            got++;
          end else begin
            idle++;
          end
        end
      end
    join
    compared++;
    if (got !== NRND) begin
      mismatched++;
      $display("[TB] FAIL rand_count got %0d want %0d", got, NRND);
    end
  endtask

  task automatic test_reset_flight;
    int stale, got;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 inValid0 = 1'b1; a0 = 24'($urandom()); b0 = 35'($urandom());
    end
    @(posedge clk);
    #1 rst = 1'b1; inValid0 = 1'b1; a0 = 24'sd7; b0 = 35'sd7;
    @(posedge clk);
    #1 rst = 1'b0; inValid0 = 1'b0;
    @(negedge clk);
    compared++;
    if (outValid0 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flight_valid got %b want 0", outValid0);
    end
    compared++;
    if ({outSat0, m0} !== '0) begin
      mismatched++;
      $display("[TB] FAIL flight_clear got s=%b m=%0h want zero", outSat0, m0);
    end
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (outValid0 !== 1'b0) stale++;
    end
    compared++;
    if (stale !== 0) begin
      mismatched++;
      $display("[TB] FAIL flight_stale got %0d stale outputs want 0", stale);
    end
    sbq.delete();
    got = 0;
    @(posedge clk);
    #1 inValid0 = 1'b1; a0 = -24'sd1000; b0 = 35'sd123456;
    sbq.push_back('{m: -128'sd123456000, sat: 1'b0, stamp: cyc});
    @(posedge clk);
    #1 inValid0 = 1'b0;
    for (int c = 0; c < 12 && got < 1; c++) begin
      @(negedge clk);
      if (outValid0) begin
        e = sbq.pop_front();
        compared++;
        if (m0 !== e.m[58:0]) begin
          mismatched++;
          $display("[TB] FAIL flight_after_m got %0h want %0h", m0, e.m[58:0]);
        end
        compared++;
        if (cyc - e.stamp !== LAT2) begin
          mismatched++;
          $display("[TB] FAIL flight_after_lat got %0d want %0d", cyc - e.stamp, LAT2);
        end
        got++;
      end
    end
    compared++;
    if (got !== 1) begin
      mismatched++;
      $display("[TB] FAIL flight_after_count got %0d want 1", got);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_random();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Last-resort guard so a stuck run still terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
